prog_bin_counter: RTL

Parametrised successor to the team's plain up/down binary counter. It keeps the same control set (syn_clr, load, en, up, d, max_tick, min_tick) and adds:
- programmable lower and upper bounds
- programmable step size
- three end-of-range modes: wrap, saturate, one-shot
- a compare-match output and a registered wrap pulse
It serves as the general-purpose timer/sequencer counter for the codebase's peripheral blocks.

---
 rtl/prog_cnt_pkg.sv | 17 +
 rtl/prog_cnt_next.sv | 60 ++++++
 rtl/prog_bin_counter.sv | 116 +++++++++++
 3 files changed

// File: rtl/prog_cnt_pkg.sv
// Shared definitions for the programmable binary counter: end-of-range
// modes and the two-state run/done FSM encoding.
package prog_cnt_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

endpackage

// File: rtl/prog_cnt_next.sv
// Combinational next-value calculator for one counting step. It assumes
// the bounds are consistent (lo <= hi) and that s is already nonzero;
// the caller decides whether the result is actually taken.
module prog_cnt_next
  import prog_cnt_pkg::*;
#(
  parameter int N      = 8,
  parameter int STEP_W = 4
) (
  input  logic [N-1:0]      q,
  input  logic [N-1:0]      lo,
  input  logic [N-1:0]      hi,
  input  logic [STEP_W-1:0] s,
  input  logic              up,
  input  logic [1:0]        mode,
  output logic [N-1:0]      nxt_q,
  output logic              wrap_evt,
  output logic              done_evt
);

  // Arithmetic width wide enough for both q and s plus one carry/borrow bit.
  localparam int W = ((N > STEP_W) ? N : STEP_W) + 1;

  mode_e mode_sel;
  assign mode_sel = mode_e'(mode);

  // Out-of-range snap, in-range step, or the end-of-range rule.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    nxt_q    = q;
    wrap_evt = 1'b0;
    done_evt = 1'b0;
    if ((q < lo) || (q > hi)) begin
      nxt_q = up ? lo : hi;
    end else if (up) begin
      // When the sum fits under hi, s < 2**N so the N-bit add is exact.
      if ((W'(q) + W'(s)) <= W'(hi)) begin
        nxt_q = q + N'(s);
      end else begin
        unique case (mode_sel)
          MODE_SAT:     nxt_q = hi;
          MODE_ONESHOT: begin nxt_q = hi; done_evt = 1'b1; end
          default:      begin nxt_q = lo; wrap_evt = 1'b1; end
        endcase
      end
    end else begin
      // No borrow means s <= q, so the N-bit subtract is exact.
      if ((W'(s) <= W'(q)) && ((W'(q) - W'(s)) >= W'(lo))) begin
        nxt_q = q - N'(s);
      end else begin
        unique case (mode_sel)
          MODE_SAT:     nxt_q = lo;
          MODE_ONESHOT: begin nxt_q = lo; done_evt = 1'b1; end
          default:      begin nxt_q = hi; wrap_evt = 1'b1; end
        endcase
      end
    end
  end

endmodule

// File: rtl/prog_bin_counter.sv
// Programmable up/down binary counter with bounds, step size, wrap /
// saturate / one-shot end-of-range modes, compare match and wrap pulse.
module prog_bin_counter
  import prog_cnt_pkg::*;
#(
  parameter int N      = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              syn_clr,
  input  logic              load,
  input  logic              en,
  input  logic              up,
  input  logic [N-1:0]      d,
  input  logic [N-1:0]      lo,
  input  logic [N-1:0]      hi,
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        mode,
  input  logic [N-1:0]      cmp,
  output logic [N-1:0]      q,
  output logic              max_tick,
  output logic              min_tick,
  output logic              cmp_match,
  output logic              wrap_pulse,
  output logic              done,
  output logic              cfg_err
);

  state_e              state, state_nxt;
  logic [STEP_W-1:0]   s;
  logic [N-1:0]        ld_val;
  logic [N-1:0]        nxt_q;
  logic                wrap_evt;
  logic                done_evt;
  logic                count_go;

  // A zero step would stall the counter, so it counts as one.
  assign s = (step == '0) ? STEP_W'(1) : step;

  assign cfg_err   = (lo > hi);
  assign max_tick  = (q == hi);
  assign min_tick  = (q == lo);
  assign cmp_match = (q == cmp);

  // With inconsistent bounds there is no sane clamp range, so d goes in raw.
  assign ld_val = cfg_err    ? d  :
                  (d < lo)   ? lo :
                  (d > hi)   ? hi : d;

  // Counting only happens when enabled, configured sanely and not finished.
  assign count_go = en && !cfg_err && (state == ST_RUN);

  prog_cnt_next #(
    .N      (N),
    .STEP_W (STEP_W)
  ) u_next (
    .q        (q),
    .lo       (lo),
    .hi       (hi),
    .s        (s),
    .up       (up),
    .mode     (mode),
    .nxt_q    (nxt_q),
    .wrap_evt (wrap_evt),
    .done_evt (done_evt)
  );

  // Counter value register with clear > load > count priority.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      q <= '0;
    end else if (syn_clr) begin
      q <= lo;
    end else if (load) begin
      q <= ld_val;
    end else if (count_go) begin
      q <= nxt_q;
    end
  end

  // Wrap pulse is high only in the cycle the wrapped value lands on q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= !syn_clr && !load && count_go && wrap_evt;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: one-shot overflow finishes, clear or load restarts.
  always_comb begin
    state_nxt = state;
    if (syn_clr || load) begin
      state_nxt = ST_RUN;
    end else if (count_go && done_evt) begin
      state_nxt = ST_DONE;
    end
  end

  // FSM output decode.
  always_comb begin
    done = (state == ST_DONE);
  end

endmodule
